// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit connection: ID/EX/MEM hazard sources in, stage enables and bubbles out.
// The pipeline side uses the master modport; the stall unit uses the slave modport.
interface hazard_stall_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             ifid_branch;
  logic             idex_MemRead;
  logic             idex_RegWrite;
  logic [4:0]       idex_rd;
  logic             idex_div;
  logic             exmem_MemRead;
  logic [4:0]       exmem_rd;
  logic             branch_taken;
  logic             jump;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             ifid_flush;
  logic             div_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, ifid_branch,
           idex_MemRead, idex_RegWrite, idex_rd, idex_div,
           exmem_MemRead, exmem_rd, branch_taken, jump,
    input  pc_write, ifid_write, idex_write, idex_bubble,
           exmem_bubble, ifid_flush, div_busy, stall_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, ifid_branch,
           idex_MemRead, idex_RegWrite, idex_rd, idex_div,
           exmem_MemRead, exmem_rd, branch_taken, jump,
    output pc_write, ifid_write, idex_write, idex_bubble,
           exmem_bubble, ifid_flush, div_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and ID-branch hazards,
// multi-cycle divide occupancy of EX, and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned DIV_CYCLES = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_unit_if.slave  hz
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [4:0]       DIV_LOAD = 5'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mrs, mrt, load_use, br_alu, br_load, br_haz, hz_stall;
  logic div_start, div_stall, any_stall;

  // Register 0 is never a real dependency, so every match is gated by rd != 0.
  always_comb begin
    mrs       = (hz.idex_rd == hz.ifid_rs);
    mrt       = (hz.idex_rd == hz.ifid_rt);
    load_use  = hz.idex_MemRead && (hz.idex_rd != 5'd0) && (mrs || (hz.ifid_uses_rt && mrt));
    br_alu    = hz.idex_RegWrite && (hz.idex_rd != 5'd0) && (mrs || mrt);
    br_load   = hz.exmem_MemRead && (hz.exmem_rd != 5'd0) &&
                ((hz.exmem_rd == hz.ifid_rs) || (hz.exmem_rd == hz.ifid_rt));
    br_haz    = hz.ifid_branch && (br_alu || br_load);
    hz_stall  = load_use || br_haz;

    div_start = (state_q == IDLE) && hz.idex_div;
    div_stall = div_start || ((state_q == BUSY) && (cnt_q >= 5'd2));
    any_stall = div_stall || hz_stall;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_count_d = stall_count_q;

    unique case (state_q)
      IDLE: begin
        if (hz.idex_div) begin
          state_d = BUSY;
          cnt_d   = DIV_LOAD;
        end
      end
      BUSY: begin
        // idex_div is not looked at here: the held divide must not retrigger itself.
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    if (any_stall && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // A divide stall holds ID/EX outright, so any ID hazard is re-evaluated after release
  // rather than bubbled now; a stalled branch must not flush on stale operands.
  always_comb begin
    hz.pc_write     = !any_stall;
    hz.ifid_write   = !any_stall;
    hz.idex_write   = !div_stall;
    hz.idex_bubble  = hz_stall && !div_stall;
    hz.exmem_bubble = div_stall;
    hz.ifid_flush   = (hz.branch_taken || hz.jump) && !any_stall;
    hz.div_busy     = div_start || (state_q == BUSY);
    hz.stall_count  = stall_count_q;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic, each cycle's
// expected response comes from a behavioural model and is checked by an independent monitor.
module tb_hazard_stall_unit;

  localparam int DIV  = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  hazard_stall_unit_if #(.CNT_W(CW)) hz_if ();

  hazard_stall_unit #(.DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hz    (hz_if.slave)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       ld_ex;
    logic       wr_ex;
    logic [4:0] rd_ex;
    logic       div;
    logic       ld_mem;
    logic [4:0] rd_mem;
    logic       taken;
    logic       jump;
  } stim_t;

  typedef struct packed {
    logic          pc_write;
    logic          ifid_write;
    logic          idex_write;
    logic          idex_bubble;
    logic          exmem_bubble;
    logic          ifid_flush;
    logic          div_busy;
    logic [CW-1:0] stall_count;
  } resp_t;

  resp_t exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Model: occ_left = EX cycles still owed to the current divide; cnt_m = stall cycles seen.
  int    occ_left = 0;
  int    cnt_m    = 0;
  stim_t prev_s   = '0;
  bit    prev_rst = 1'b1;

  function automatic bit id_hazard(input stim_t s);
    bit lu, a, b;
    lu = s.ld_ex && s.rd_ex != 0 && (s.rd_ex == s.rs || (s.uses_rt && s.rd_ex == s.rt));
    a  = s.wr_ex && s.rd_ex != 0 && (s.rd_ex == s.rs || s.rd_ex == s.rt);
    b  = s.ld_mem && s.rd_mem != 0 && (s.rd_mem == s.rs || s.rd_mem == s.rt);
    return lu || (s.branch && (a || b));
  endfunction

  function automatic int occupancy(input stim_t s);
    return (occ_left == 0 && s.div) ? DIV : occ_left;
  endfunction

  task automatic drive(input stim_t s);
    hz_if.ifid_rs       = s.rs;
    hz_if.ifid_rt       = s.rt;
    hz_if.ifid_uses_rt  = s.uses_rt;
    hz_if.ifid_branch   = s.branch;
    hz_if.idex_MemRead  = s.ld_ex;
    hz_if.idex_RegWrite = s.wr_ex;
    hz_if.idex_rd       = s.rd_ex;
    hz_if.idex_div      = s.div;
    hz_if.exmem_MemRead = s.ld_mem;
    hz_if.exmem_rd      = s.rd_mem;
    hz_if.branch_taken  = s.taken;
    hz_if.jump          = s.jump;
  endtask

  task automatic step(input stim_t s, input bit r, input string tag);
    int    occ;
    bit    dst, hst;
    resp_t e;
    @(posedge clk_i);
    if (!prev_rst) begin
      occ = occupancy(prev_s);
      if ((occ > 1 || id_hazard(prev_s)) && cnt_m < CMAX) cnt_m = cnt_m + 1;
      occ_left = (occ > 0) ? occ - 1 : 0;
    end
    #1;
    rst_i = r;
    drive(s);
    if (r) begin
      occ_left = 0;
      cnt_m    = 0;
    end
    occ            = occupancy(s);
    dst            = (occ > 1);
    hst            = id_hazard(s);
    e.pc_write     = !(dst || hst);
    e.ifid_write   = !(dst || hst);
    e.idex_write   = !dst;
    e.idex_bubble  = hst && !dst;
    e.exmem_bubble = dst;
    e.ifid_flush   = (s.taken || s.jump) && !dst && !hst;
    e.div_busy     = (occ > 0);
    e.stall_count  = CW'(cnt_m);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    prev_s   = s;
    prev_rst = r;
  endtask

  initial begin : monitor
    resp_t got, e;
    string t;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        got = {hz_if.pc_write, hz_if.ifid_write, hz_if.idex_write, hz_if.idex_bubble,
               hz_if.exmem_bubble, hz_if.ifid_flush, hz_if.div_busy, hz_if.stall_count};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got pc,ifid,idex,ibub,ebub,flush,busy=%b cnt=%0d, expected %b cnt=%0d",
                   t, $time, got[CW+6:CW], got.stall_count, e[CW+6:CW], e.stall_count);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    bit    r;
    drive('0);
    step('0, 1'b1, "reset");
    step('0, 1'b1, "reset");
    step('0, 1'b0, "idle");

    // Load-use on rs, then rd=0 never stalls.
    s = '0; s.ld_ex = 1; s.rd_ex = 8; s.rs = 8;
    step(s, 1'b0, "load_use");
    step('0, 1'b0, "load_use_after");
    s.rd_ex = 0;
    step(s, 1'b0, "load_rd0");

    // rt only counts when the ID instruction actually reads rt.
    s = '0; s.ld_ex = 1; s.rd_ex = 9; s.rt = 9;
    step(s, 1'b0, "rt_unused");
    s.uses_rt = 1;
    step(s, 1'b0, "rt_used");
    step('0, 1'b0, "rt_after");

    // Load feeding a branch: EX then MEM stall, flush only once operands are ready.
    s = '0; s.branch = 1; s.rs = 5; s.taken = 1; s.ld_ex = 1; s.wr_ex = 1; s.rd_ex = 5;
    step(s, 1'b0, "ldbr_ex");
    s.ld_ex = 0; s.wr_ex = 0; s.rd_ex = 0; s.ld_mem = 1; s.rd_mem = 5;
    step(s, 1'b0, "ldbr_mem");
    s.ld_mem = 0; s.rd_mem = 0;
    step(s, 1'b0, "ldbr_flush");
    s = '0; s.jump = 1;
    step(s, 1'b0, "jump_flush");

    // Single divide held in EX, then two back-to-back.
    s = '0; s.div = 1;
    for (int i = 0; i < DIV; i++) step(s, 1'b0, "div_single");
    step('0, 1'b0, "div_done");
    for (int i = 0; i < 2 * DIV; i++) step(s, 1'b0, "div_b2b");
    step('0, 1'b0, "div_b2b_done");

    // Divide overlapping a load-use in ID; the hazard resolves after release.
    s = '0; s.div = 1; s.ld_ex = 1; s.rd_ex = 7; s.rs = 7; s.taken = 1;
    for (int i = 0; i < DIV; i++) step(s, 1'b0, "div_lu");
    s.div = 0;
    step(s, 1'b0, "lu_after_div");
    step('0, 1'b0, "lu_released");

    // Reset in the middle of a divide.
    s = '0; s.div = 1;
    step(s, 1'b0, "div_pre_rst");
    step(s, 1'b0, "div_pre_rst");
    step('0, 1'b1, "rst_mid_div");
    step('0, 1'b0, "post_rst");

    // Long stall drives the counter into saturation.
    s = '0; s.ld_ex = 1; s.rd_ex = 3; s.rt = 3; s.uses_rt = 1;
    for (int i = 0; i < 20; i++) step(s, 1'b0, "saturate");
    step('0, 1'b0, "saturate_hold");

    // Random traffic over a small register range so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.uses_rt = 1'($urandom_range(0, 1));
      s.branch  = 1'($urandom_range(0, 1));
      s.ld_ex   = ($urandom_range(0, 3) == 0);
      s.wr_ex   = 1'($urandom_range(0, 1));
      s.rd_ex   = 5'($urandom_range(0, 3));
      s.div     = ($urandom_range(0, 9) == 0);
      s.ld_mem  = ($urandom_range(0, 3) == 0);
      s.rd_mem  = 5'($urandom_range(0, 3));
      s.taken   = 1'($urandom_range(0, 1));
      s.jump    = ($urandom_range(0, 7) == 0);
      r         = ($urandom_range(0, 99) == 0);
      step(s, r, "random");
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
